// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I controller: opcodes, widths,
// state encoding and the latched decoder-class record.
package multicycle_ctrl_pkg;

    localparam int LEN_WORD     = 32;
    localparam int LEN_REG_ADDR = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_MEML   = 7'b0000011;
    localparam logic [6:0] OP_MEMS   = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Field order matches the {alu, mem, jump, branch, subst, store} concatenation.
    typedef struct packed {
        logic alu;
        logic mem;
        logic jump;
        logic branch;
        logic subst;
        logic store;
    } cls_t;

    function automatic logic single_class(input cls_t c);
        return $onehot({c.alu, c.mem, c.jump, c.branch, c.subst});
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle RV32I core: fetch, decode, execute,
// data access, write-back and PC update, plus a retired-instruction counter.
module multicycle_ctrl #(
    parameter int LEN_WORD     = multicycle_ctrl_pkg::LEN_WORD,
    parameter int LEN_REG_ADDR = multicycle_ctrl_pkg::LEN_REG_ADDR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    imem_req,
    input  logic                    imem_ack,
    output logic                    inst_we,
    input  logic                    dec_alu,
    input  logic                    dec_mem,
    input  logic                    dec_jump,
    input  logic                    dec_branch,
    input  logic                    dec_subst,
    input  logic                    dec_store,
    input  logic [LEN_REG_ADDR-1:0] a_rd,
    input  logic                    br_taken,
    output logic                    dmem_req,
    output logic                    dmem_we,
    input  logic                    dmem_ack,
    output logic                    reg_we,
    output logic                    pc_we,
    output logic                    pc_sel,
    output logic                    busy,
    output logic                    halted,
    output logic [LEN_WORD-1:0]     retired,
    output logic [2:0]              state
);
    import multicycle_ctrl_pkg::*;

    state_t                  cur;
    cls_t                    cls_in;
    cls_t                    cls_q;
    logic [LEN_REG_ADDR-1:0] rd_q;

    assign cls_in = {dec_alu, dec_mem, dec_jump, dec_branch, dec_subst, dec_store};

    // Decoder outputs are only trusted in DECODE; later states use the copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= ST_IDLE;
            cls_q   <= '0;
            rd_q    <= '0;
            retired <= '0;
        end else begin
            if (pc_we) begin
                retired <= retired + LEN_WORD'(1);
            end
            case (cur)
                ST_IDLE: begin
                    if (start) cur <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) cur <= ST_DECODE;
                end
                ST_DECODE: begin
                    cls_q <= cls_in;
                    rd_q  <= a_rd;
                    cur   <= single_class(cls_in) ? ST_EXEC : ST_HALT;
                end
                ST_EXEC: begin
                    if (cls_q.branch) cur <= ST_FETCH;
                    else if (cls_q.mem) cur <= ST_MEM;
                    else if (cls_q.alu || cls_q.subst || cls_q.jump) cur <= ST_WB;
                    else cur <= ST_HALT;
                end
                ST_MEM: begin
                    if (dmem_ack) cur <= cls_q.store ? ST_FETCH : ST_WB;
                end
                ST_WB: begin
                    cur <= ST_FETCH;
                end
                ST_HALT: begin
                    cur <= ST_HALT;
                end
                default: begin
                    cur <= ST_HALT;
                end
            endcase
        end
    end

    // Strobes decode from the state register and latched flags; only the
    // EXEC branch select and the ack-qualified strobes look at live inputs.
    always_comb begin
        imem_req = 1'b0;
        inst_we  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        case (cur)
            ST_FETCH: begin
                imem_req = 1'b1;
                inst_we  = imem_ack;
            end
            ST_EXEC: begin
                if (cls_q.branch) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls_q.store;
                pc_we    = dmem_ack && cls_q.store;
            end
            ST_WB: begin
                reg_we = (rd_q != '0);
                pc_we  = 1'b1;
                pc_sel = cls_q.jump;
            end
            default: begin
            end
        endcase
    end

    assign busy   = (cur != ST_IDLE) && (cur != ST_HALT);
    assign halted = (cur == ST_HALT);
    assign state  = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction traces are checked
// against an opcode-level timing model kept here.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_JMP = 3, C_BR = 4, C_SUB = 5, C_ILL = 6;

    typedef int trace_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        br_taken = 1'b0;
    logic        dec_alu = 1'b0, dec_mem = 1'b0, dec_jump = 1'b0;
    logic        dec_branch = 1'b0, dec_subst = 1'b0, dec_store = 1'b0;
    logic [4:0]  a_rd = '0;
    logic        imem_req, inst_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, busy, halted;
    logic [31:0] retired;
    logic [2:0]  state;

    int vectors = 0;
    int miscompares = 0;
    int model_retired = 0;
    int tr_q[$];
    int r_lat, r_ireq, r_inst, r_dreq, r_dwe, r_regwe, r_pcwe;
    logic r_sel;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .inst_we(inst_we),
        .dec_alu(dec_alu), .dec_mem(dec_mem), .dec_jump(dec_jump),
        .dec_branch(dec_branch), .dec_subst(dec_subst), .dec_store(dec_store),
        .a_rd(a_rd), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .busy(busy), .halted(halted), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int class_of(input logic [6:0] op);
        case (op)
            OP_ALU, OP_ALUI:  return C_ALU;
            OP_MEML:          return C_LD;
            OP_MEMS:          return C_ST;
            OP_JAL, OP_JALR:  return C_JMP;
            OP_BRANCH:        return C_BR;
            OP_LUI, OP_AUIPC: return C_SUB;
            default:          return C_ILL;
        endcase
    endfunction

    function automatic int exp_latency(input int cls, input int iw, input int dw);
        int base;
        base = iw + 2;
        case (cls)
            C_BR:    return base + 1;
            C_ST:    return base + 2 + dw;
            C_LD:    return base + 3 + dw;
            default: return base + 2;
        endcase
    endfunction

    function automatic trace_t exp_trace(input int cls, input int iw, input int dw);
        trace_t t;
        repeat (iw + 1) t.push_back(1);
        t.push_back(2);
        t.push_back(3);
        if (cls == C_LD || cls == C_ST) repeat (dw + 1) t.push_back(4);
        if (cls != C_BR && cls != C_ST) t.push_back(5);
        return t;
    endfunction

    function automatic bit same_trace(input trace_t e);
        if (e.size() != tr_q.size()) return 1'b0;
        foreach (e[i]) if (e[i] != tr_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- drivers ----------------
    task automatic reset_and_start();
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_retired = 0;
        vectors++;
        if (state !== 3'd1 || busy !== 1'b1)
            $display("FAIL start_to_fetch: state=%0d busy=%b, want state=1 busy=1", state, busy);
        if (state !== 3'd1 || busy !== 1'b1) miscompares++;
    endtask

    // One instruction from FETCH until its pc_we; decoder/branch/ack inputs
    // carry random junk whenever they are not supposed to matter.
    task automatic run_instr(input int cls, input logic [4:0] rd, input logic br,
                             input int iw, input int dw);
        int  fcnt = 0;
        int  mcnt = 0;
        bit  done = 1'b0;
        r_lat = 0; r_ireq = 0; r_inst = 0; r_dreq = 0; r_dwe = 0; r_regwe = 0; r_pcwe = 0;
        r_sel = 1'bx;
        tr_q.delete();
        for (int c = 0; c < 64 && !done; c++) begin
            start    = 1'($urandom_range(0, 1));
            imem_ack = (state == 3'd1) ? (fcnt == iw) : 1'($urandom_range(0, 1));
            dmem_ack = (state == 3'd4) ? (mcnt == dw) : 1'($urandom_range(0, 1));
            br_taken = (state == 3'd3) ? br : 1'($urandom_range(0, 1));
            if (state == 3'd2) begin
                dec_alu = (cls == C_ALU); dec_mem = (cls == C_LD || cls == C_ST);
                dec_jump = (cls == C_JMP); dec_branch = (cls == C_BR);
                dec_subst = (cls == C_SUB); dec_store = (cls == C_ST); a_rd = rd;
            end else begin
                {dec_alu, dec_mem, dec_jump, dec_branch, dec_subst, dec_store} = 6'($urandom);
                a_rd = 5'($urandom);
            end
            #1;
            tr_q.push_back(int'(state));
            r_lat++;
            if (imem_req) r_ireq++;
            if (inst_we) r_inst++;
            if (dmem_req) begin r_dreq++; if (dmem_we) r_dwe++; end
            if (reg_we) r_regwe++;
            if (pc_we) begin r_pcwe++; r_sel = pc_sel; done = 1'b1; end
            if (state == 3'd1) fcnt++;
            if (state == 3'd4) mcnt++;
            @(posedge clk); #1;
        end
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        if (done) model_retired++;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL instr_timeout: no pc_we within 64 cycles (class %0d), want one", cls);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        vectors++;
        if ({state, halted, busy, imem_req, inst_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel} !== 12'b0
            || retired !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d halted=%b busy=%b strobes=%b%b%b%b%b%b%b retired=%0d, want all 0",
                     state, halted, busy, imem_req, inst_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, retired);
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if (state !== 3'd0 || imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold: state=%0d imem_req=%b, want 0 0", state, imem_req);
            end
        end
    endtask

    task automatic test_add();
        trace_t e;
        reset_and_start();
        run_instr(C_ALU, 5'd3, 1'b0, 0, 0);
        e = '{1, 2, 3, 5};
        vectors++;
        if (!same_trace(e)) begin
            miscompares++;
            $display("FAIL add_trace: got %p, want %p", tr_q, e);
        end
        vectors++;
        if (r_lat !== 4 || r_regwe !== 1 || r_sel !== 1'b0 || retired !== 32'd1) begin
            miscompares++;
            $display("FAIL add_result: lat=%0d reg_we=%0d sel=%b retired=%0d, want 4 1 0 1",
                     r_lat, r_regwe, r_sel, retired);
        end
    endtask

    task automatic test_branch();
        reset_and_start();
        run_instr(C_BR, 5'd9, 1'b1, 0, 0);
        vectors++;
        if (r_lat !== 3 || r_sel !== 1'b1 || r_regwe !== 0) begin
            miscompares++;
            $display("FAIL beq_taken: lat=%0d sel=%b reg_we=%0d, want 3 1 0", r_lat, r_sel, r_regwe);
        end
        run_instr(C_BR, 5'd4, 1'b0, 0, 0);
        vectors++;
        if (r_lat !== 3 || r_sel !== 1'b0 || r_regwe !== 0 || retired !== 32'd2) begin
            miscompares++;
            $display("FAIL bne_not_taken: lat=%0d sel=%b reg_we=%0d retired=%0d, want 3 0 0 2",
                     r_lat, r_sel, r_regwe, retired);
        end
    endtask

    task automatic test_load_store();
        trace_t e;
        reset_and_start();
        run_instr(C_LD, 5'd7, 1'b0, 0, 3);
        vectors++;
        if (r_lat !== 8 || r_dreq !== 4 || r_dwe !== 0 || r_regwe !== 1) begin
            miscompares++;
            $display("FAIL load_wait3: lat=%0d dmem_req=%0d dmem_we=%0d reg_we=%0d, want 8 4 0 1",
                     r_lat, r_dreq, r_dwe, r_regwe);
        end
        run_instr(C_ST, 5'd2, 1'b0, 0, 0);
        e = '{1, 2, 3, 4};
        vectors++;
        if (!same_trace(e) || r_lat !== 4 || r_dwe !== 1 || r_regwe !== 0 || r_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL store: trace=%p lat=%0d dmem_we=%0d reg_we=%0d sel=%b, want {1,2,3,4} 4 1 0 0",
                     tr_q, r_lat, r_dwe, r_regwe, r_sel);
        end
        vectors++;
        if (retired !== 32'd2) begin
            miscompares++;
            $display("FAIL load_store_retired: got %0d, want 2", retired);
        end
    endtask

    task automatic test_rd0_jal();
        reset_and_start();
        run_instr(C_ALU, 5'd0, 1'b0, 1, 0);
        vectors++;
        if (r_regwe !== 0 || r_pcwe !== 1 || r_lat !== 5) begin
            miscompares++;
            $display("FAIL addi_rd0: reg_we=%0d pc_we=%0d lat=%0d, want 0 1 5", r_regwe, r_pcwe, r_lat);
        end
        run_instr(C_JMP, 5'd1, 1'b0, 0, 0);
        vectors++;
        if (r_regwe !== 1 || r_sel !== 1'b1 || retired !== 32'd2) begin
            miscompares++;
            $display("FAIL jal_rd1: reg_we=%0d sel=%b retired=%0d, want 1 1 2", r_regwe, r_sel, retired);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[9];
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_MEML, OP_MEMS, OP_ALUI, OP_ALU};
        reset_and_start();
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [4:0] rd;
            logic       br;
            int         cls, iw, dw, e_lat, e_reg, e_dreq, e_dwe;
            logic       e_sel;
            op  = ops[$urandom_range(0, 8)];
            cls = class_of(op);
            rd  = 5'($urandom_range(0, 31));
            br  = 1'($urandom_range(0, 1));
            iw  = $urandom_range(0, 3);
            dw  = $urandom_range(0, 3);
            run_instr(cls, rd, br, iw, dw);
            e_lat  = exp_latency(cls, iw, dw);
            e_reg  = (cls != C_BR && cls != C_ST && rd != 0) ? 1 : 0;
            e_sel  = (cls == C_BR) ? br : (cls == C_JMP);
            e_dreq = (cls == C_LD || cls == C_ST) ? dw + 1 : 0;
            e_dwe  = (cls == C_ST) ? dw + 1 : 0;
            vectors++;
            if (r_lat !== e_lat || r_regwe !== e_reg || r_sel !== e_sel || r_pcwe !== 1) begin
                miscompares++;
                $display("FAIL rand_timing[%0d] op=%b: lat=%0d reg_we=%0d sel=%b pc_we=%0d, want %0d %0d %b 1",
                         n, op, r_lat, r_regwe, r_sel, r_pcwe, e_lat, e_reg, e_sel);
            end
            vectors++;
            if (r_ireq !== iw + 1 || r_inst !== 1 || r_dreq !== e_dreq || r_dwe !== e_dwe) begin
                miscompares++;
                $display("FAIL rand_mem[%0d] op=%b: imem_req=%0d inst_we=%0d dmem_req=%0d dmem_we=%0d, want %0d 1 %0d %0d",
                         n, op, r_ireq, r_inst, r_dreq, r_dwe, iw + 1, e_dreq, e_dwe);
            end
            vectors++;
            if (!same_trace(exp_trace(cls, iw, dw)) || retired !== 32'(model_retired)) begin
                miscompares++;
                $display("FAIL rand_trace[%0d]: trace=%p retired=%0d, want %p retired=%0d",
                         n, tr_q, retired, exp_trace(cls, iw, dw), model_retired);
            end
        end
    endtask

    task automatic test_halt();
        for (int v = 0; v < 2; v++) begin
            reset_and_start();
            run_instr(C_SUB, 5'd6, 1'b0, 0, 0);
            imem_ack = 1'b1;
            @(posedge clk); #1;
            imem_ack = 1'b0;
            {dec_alu, dec_mem, dec_jump, dec_branch, dec_subst, dec_store} = (v == 0) ? 6'b000000 : 6'b100100;
            #1;
            vectors++;
            if (state !== 3'd2 || pc_we !== 1'b0 || reg_we !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_decode[%0d]: state=%0d pc_we=%b reg_we=%b, want 2 0 0", v, state, pc_we, reg_we);
            end
            @(posedge clk); #1;
            vectors++;
            if (state !== 3'd6 || halted !== 1'b1 || busy !== 1'b0 || retired !== 32'd1) begin
                miscompares++;
                $display("FAIL halt_entry[%0d]: state=%0d halted=%b busy=%b retired=%0d, want 6 1 0 1",
                         v, state, halted, busy, retired);
            end
            for (int c = 0; c < 20; c++) begin
                start    = 1'($urandom_range(0, 1)) | (c == 0);
                imem_ack = 1'($urandom_range(0, 1));
                dmem_ack = 1'($urandom_range(0, 1));
                {dec_alu, dec_mem, dec_jump, dec_branch, dec_subst, dec_store} = 6'($urandom);
                @(posedge clk); #1;
                vectors++;
                if ({state, halted, imem_req, dmem_req, reg_we, pc_we} !== 8'b110_10000 || retired !== 32'd1) begin
                    miscompares++;
                    $display("FAIL halt_absorb[%0d/%0d]: state=%0d halted=%b imem_req=%b dmem_req=%b reg_we=%b pc_we=%b retired=%0d, want 6 1 0 0 0 0 1",
                             v, c, state, halted, imem_req, dmem_req, reg_we, pc_we, retired);
                end
            end
            start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        end
    endtask

    task automatic test_reset_mid_mem();
        reset_and_start();
        run_instr(C_ALU, 5'd8, 1'b0, 0, 0);
        for (int c = 0; c < 10 && state != 3'd4; c++) begin
            imem_ack = (state == 3'd1);
            dmem_ack = 1'b0;
            {dec_alu, dec_mem, dec_jump, dec_branch, dec_subst, dec_store} = 6'b010000;
            a_rd = 5'd5;
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || retired !== 32'd1) begin
            miscompares++;
            $display("FAIL pre_reset_mem: state=%0d dmem_req=%b dmem_we=%b retired=%0d, want 4 1 0 1",
                     state, dmem_req, dmem_we, retired);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({state, imem_req, inst_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, halted} !== 11'b0
            || retired !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_in_mem: state=%0d strobes=%b%b%b%b%b%b%b retired=%0d, want all 0",
                     state, imem_req, inst_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, retired);
        end
        dmem_ack = 1'b1; imem_ack = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            vectors++;
            if (state !== 3'd0 || dmem_req !== 1'b0 || pc_we !== 1'b0 || retired !== 32'd0) begin
                miscompares++;
                $display("FAIL late_ack_ignored: state=%0d dmem_req=%b pc_we=%b retired=%0d, want 0 0 0 0",
                         state, dmem_req, pc_we, retired);
            end
        end
        dmem_ack = 1'b0; imem_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_branch();
        test_load_store();
        test_rd0_jal();
        test_random();
        test_halt();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
